// File: rtl/imm_narrow_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module : imm_narrow_packer_pkg
// Brief  : Shared widths and packer state encoding for the immediate packer.
// Rev    : 1.0
// ============================================================================
package imm_narrow_packer_pkg;

  localparam int c_IN_W   = 8;
  localparam int c_IMM_W  = 3;
  localparam int c_WORD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } pk_state_e;

  // Occupancy class of the accumulator for a given bit count.
  function automatic pk_state_e state_of(input int cnt, input int word_w);
    if (cnt == 0)
      return ST_IDLE;
    else if (cnt < word_w)
      return ST_FILL;
    else
      return ST_FULL;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_narrow_packer_narrow.sv
`default_nettype none
// ============================================================================
// Module : imm_narrow
// Brief  : Combinational signed narrowing IN_W -> FIELD_W with range flag.
// Rev    : 1.0
// ============================================================================
module imm_narrow #(
  parameter int IN_W     = 8,
  parameter int FIELD_W  = 3,
  parameter int SATURATE = 1
) (
  input  logic [IN_W-1:0]    in_data,
  output logic [FIELD_W-1:0] field,
  output logic               ovf
);

  // A value fits when every bit from the field sign bit upward is a copy of it.
  logic [IN_W-FIELD_W:0] w_hi;
  logic                  w_in_range;

  assign w_hi       = in_data[IN_W-1:FIELD_W-1];
  assign w_in_range = (&w_hi) || !(|w_hi);
  assign ovf        = !w_in_range;

  generate
    if (SATURATE != 0) begin : g_sat
      assign field = w_in_range      ? in_data[FIELD_W-1:0] :
                     in_data[IN_W-1] ? {1'b1, {(FIELD_W-1){1'b0}}} :
                                       {1'b0, {(FIELD_W-1){1'b1}}};
    end else begin : g_trunc
      assign field = in_data[FIELD_W-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/imm_narrow_packer.sv
`default_nettype none
// ============================================================================
// Module : imm_narrow_packer
// Brief  : Narrows signed values to immediate fields and packs them LSB-first.
// Rev    : 1.0
// ============================================================================
module imm_narrow_packer
  import imm_narrow_packer_pkg::*;
#(
  parameter int IN_W     = c_IN_W,
  parameter int FIELD_W  = c_IMM_W,
  parameter int OUT_W    = c_WORD_W,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             flush_req,
  output logic             flush_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             ovf
);

  localparam int ACC_W = OUT_W + FIELD_W - 1;
  localparam int CNT_W = $clog2(ACC_W + 1);

  logic [FIELD_W-1:0] w_field;
  logic               w_field_ovf;

  imm_narrow #(
    .IN_W    (IN_W),
    .FIELD_W (FIELD_W),
    .SATURATE(SATURATE)
  ) u_narrow (
    .in_data(in_data),
    .field  (w_field),
    .ovf    (w_field_ovf)
  );

  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  pk_state_e        r_state, w_state_nxt;
  logic             r_run;
  logic             r_flush_hold, w_flush_hold_nxt;
  logic [OUT_W-1:0] r_out_data, w_out_data_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_out_last, w_out_last_nxt;
  logic             r_flush_done, w_flush_done_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             w_out_free, w_accept, w_emit, w_flush;

  assign in_ready   = r_run && (r_state != ST_FULL);
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign flush_done = r_flush_done;
  assign ovf        = r_ovf;

  always_comb begin
    w_out_free       = !r_out_valid || out_ready;
    w_accept         = in_valid && in_ready;
    w_emit           = (r_state == ST_FULL) && w_out_free;
    // r_flush_hold keeps a held-high request from re-firing until new bits arrive.
    w_flush          = flush_req && !in_valid && (r_state != ST_FULL) &&
                       w_out_free && !r_flush_hold;
    w_acc_nxt        = r_acc;
    w_cnt_nxt        = r_cnt;
    w_out_data_nxt   = r_out_data;
    w_out_valid_nxt  = r_out_valid && !out_ready;
    w_out_last_nxt   = r_out_last;
    w_flush_done_nxt = 1'b0;
    w_flush_hold_nxt = r_flush_hold && flush_req;
    w_ovf_nxt        = w_accept && w_field_ovf;

    if (w_accept) begin
      w_acc_nxt        = r_acc | (ACC_W'(w_field) << r_cnt);
      w_cnt_nxt        = r_cnt + CNT_W'(FIELD_W);
      w_flush_hold_nxt = 1'b0;
    end else if (w_emit) begin
      w_out_data_nxt  = r_acc[OUT_W-1:0];
      w_out_valid_nxt = 1'b1;
      w_out_last_nxt  = 1'b0;
      w_acc_nxt       = r_acc >> OUT_W;
      w_cnt_nxt       = r_cnt - CNT_W'(OUT_W);
    end else if (w_flush) begin
      w_flush_done_nxt = 1'b1;
      w_flush_hold_nxt = 1'b1;
      if (r_state == ST_FILL) begin
        w_out_data_nxt  = r_acc[OUT_W-1:0];
        w_out_valid_nxt = 1'b1;
        w_out_last_nxt  = 1'b1;
        w_acc_nxt       = '0;
        w_cnt_nxt       = '0;
      end
    end

    w_state_nxt = state_of(int'(w_cnt_nxt), OUT_W);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_state      <= ST_IDLE;
      r_run        <= 1'b0;
      r_flush_hold <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_flush_done <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_acc        <= w_acc_nxt;
      r_cnt        <= w_cnt_nxt;
      r_state      <= w_state_nxt;
      r_run        <= 1'b1;
      r_flush_hold <= w_flush_hold_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_last   <= w_out_last_nxt;
      r_flush_done <= w_flush_done_nxt;
      r_ovf        <= w_ovf_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_narrow_packer.sv
`default_nettype none
// ============================================================================
// Module : tb_imm_narrow_packer
// Brief  : Bench for imm_narrow_packer: saturating and truncating instances.
// Rev    : 1.0
// ============================================================================
module tb_imm_narrow_packer;

  localparam int c_FW  = 3;
  localparam int c_QSZ = 8192;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       flush_req = 1'b0;
  logic       out_ready = 1'b1;

  logic       ir [2];
  logic       fd [2];
  logic       ov [2];
  logic [7:0] od [2];
  logic       ol [2];
  logic       ovo[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_narrow_packer #(.IN_W(8), .FIELD_W(3), .OUT_W(8), .SATURATE(1)) u_dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .flush_req(flush_req), .flush_done(fd[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_last(ol[0]), .ovf(ovo[0])
  );

  imm_narrow_packer #(.IN_W(8), .FIELD_W(3), .OUT_W(8), .SATURATE(0)) u_dut_trunc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .flush_req(flush_req), .flush_done(fd[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_last(ol[1]), .ovf(ovo[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one value and hold it until accepted; returns just after the accepting edge.
  task automatic push(input logic [7:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!ir[0] && n < 50) begin
      step();
      n++;
    end
    if (!ir[0]) chk("push_timeout", 32'(ir[0]), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Raise flush_req until flush_done; returns just after the edge that raised it.
  task automatic do_flush();
    int n;
    n = 0;
    flush_req = 1'b1;
    step();
    while (!fd[0] && n < 50) begin
      step();
      n++;
    end
    flush_req = 1'b0;
    if (!fd[0]) chk("flush_timeout", 32'(fd[0]), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    flush_req = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Reference model: a FIFO of field bits per instance, filled from the narrowing
  // rule in plain integer arithmetic and drained 8 bits per handshaken word.
  bit         mb [2][c_QSZ];
  int         hd [2];
  int         tl [2];
  bit         pov[2];
  bit         hv [2];
  logic [7:0] hdt[2];

  initial begin
    int         sv, f, take;
    logic [7:0] w;
    for (int k = 0; k < 2; k++) begin
      hd[k] = 0; tl[k] = 0; pov[k] = 0; hv[k] = 0; hdt[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (reset) begin
          hd[k] = tl[k]; pov[k] = 0; hv[k] = 0;
        end else begin
          chk("mon_ovf", 32'(ovo[k]), 32'(pov[k]));
          if (hv[k] && ov[k]) chk("mon_hold", 32'(od[k]), 32'(hdt[k]));
          if (ov[k] && out_ready) begin
            take = 8;
            if (ol[k] && (tl[k] - hd[k]) < 8) take = tl[k] - hd[k];
            w = '0;
            for (int j = 0; j < take; j++) begin
              if (hd[k] < tl[k]) begin
                w[j] = mb[k][hd[k] % c_QSZ];
                hd[k]++;
              end
            end
            chk("mon_word", 32'(od[k]), 32'(w));
          end
          hv[k]  = ov[k] && !out_ready;
          hdt[k] = od[k];
          pov[k] = 0;
          if (in_valid && ir[k]) begin
            sv     = int'($signed(in_data));
            pov[k] = (sv < -4) || (sv > 3);
            f      = sv;
            if (k == 0) f = (sv < -4) ? -4 : (sv > 3) ? 3 : sv;
            for (int j = 0; j < c_FW; j++) begin
              mb[k][tl[k] % c_QSZ] = f[j];
              tl[k]++;
            end
          end
        end
      end
    end
  end

  typedef struct {
    logic [7:0] din;
    logic [2:0] fs;
    logic [2:0] ft;
    logic       ov;
  } vec_t;

  vec_t tv[10];

  initial begin
    tv[0] = '{8'h00, 3'b000, 3'b000, 1'b0};
    tv[1] = '{8'h03, 3'b011, 3'b011, 1'b0};
    tv[2] = '{8'h04, 3'b011, 3'b100, 1'b1};
    tv[3] = '{8'h7F, 3'b011, 3'b111, 1'b1};
    tv[4] = '{8'h80, 3'b100, 3'b000, 1'b1};
    tv[5] = '{8'hFC, 3'b100, 3'b100, 1'b0};
    tv[6] = '{8'hFB, 3'b100, 3'b011, 1'b1};
    tv[7] = '{8'hFF, 3'b111, 3'b111, 1'b0};
    tv[8] = '{8'h0C, 3'b011, 3'b100, 1'b1};
    tv[9] = '{8'hF8, 3'b100, 3'b000, 1'b1};

    // Reset state
    step();
    step();
    chk("rst_in_ready", 32'(ir[0]), 32'd0);
    chk("rst_out_valid", 32'(ov[0]), 32'd0);
    chk("rst_out_data", 32'(od[0]), 32'd0);
    chk("rst_out_last", 32'(ol[0]), 32'd0);
    chk("rst_flush_done", 32'(fd[0]), 32'd0);
    chk("rst_ovf", 32'(ovo[0]), 32'd0);
    reset = 1'b0;
    step();
    chk("rst_ready_after", 32'(ir[0]), 32'd1);

    // Single value then flush exposes the narrowed field in bits [2:0]
    for (int i = 0; i < 10; i++) begin
      push(tv[i].din);
      chk("tab_ovf_sat", 32'(ovo[0]), 32'(tv[i].ov));
      chk("tab_ovf_trunc", 32'(ovo[1]), 32'(tv[i].ov));
      do_flush();
      chk("tab_field_sat", 32'(od[0]), {29'd0, tv[i].fs});
      chk("tab_field_trunc", 32'(od[1]), {29'd0, tv[i].ft});
      chk("tab_last", 32'(ol[0]), 32'd1);
      step();
    end

    // Three fields make one full word
    do_reset();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    step();
    chk("t1_valid", 32'(ov[0]), 32'd1);
    chk("t1_data", 32'(od[0]), 32'hD1);
    chk("t1_last", 32'(ol[0]), 32'd0);
    chk("t1_ready", 32'(ir[0]), 32'd1);
    do_flush();
    chk("t1_flush_data", 32'(od[0]), 32'h00);
    chk("t1_flush_last", 32'(ol[0]), 32'd1);
    step();

    // Saturation of both extremes, then the packed remainder
    do_reset();
    push(8'h7F); chk("t2_ovf0", 32'(ovo[0]), 32'd1);
    push(8'h80); chk("t2_ovf1", 32'(ovo[0]), 32'd1);
    push(8'hFC); chk("t2_ovf2", 32'(ovo[0]), 32'd0);
    push(8'h03); chk("t2_ovf3", 32'(ovo[0]), 32'd0);
    do_flush();
    chk("t2_flush_data", 32'(od[0]), 32'h07);
    step();

    // Flush a partial word, then flush with nothing pending
    do_reset();
    push(8'hFF);
    do_flush();
    chk("t3_data", 32'(od[0]), 32'h07);
    chk("t3_last", 32'(ol[0]), 32'd1);
    chk("t3_valid", 32'(ov[0]), 32'd1);
    step();
    chk("t3_done_pulse", 32'(fd[0]), 32'd0);
    do_flush();
    chk("t3_empty_done", 32'(fd[0]), 32'd1);
    chk("t3_empty_noword", 32'(ov[0]), 32'd0);
    step();

    // Output stall: held word stays put, input backs up, order preserved on release
    do_reset();
    out_ready = 1'b0;
    push(8'h01); push(8'h02); push(8'h03);
    push(8'hFD); push(8'hFE); push(8'h02);
    for (int i = 0; i < 3; i++) begin
      chk("t4_full_ready", 32'(ir[0]), 32'd0);
      chk("t4_hold_data", 32'(od[0]), 32'hD1);
      chk("t4_hold_valid", 32'(ov[0]), 32'd1);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("t4_next_valid", 32'(ov[0]), 32'd1);
    chk("t4_next_data", 32'(od[0]), 32'h6A);
    do_flush();
    chk("t4_flush_data", 32'(od[0]), 32'h01);
    step();

    // Reset with partial bits and a held word
    do_reset();
    out_ready = 1'b0;
    push(8'hFF);
    do_flush();
    step();
    push(8'h01);
    push(8'h02);
    chk("t5_pre_valid", 32'(ov[0]), 32'd1);
    reset = 1'b1;
    step();
    chk("t5_rst_valid", 32'(ov[0]), 32'd0);
    chk("t5_rst_data", 32'(od[0]), 32'd0);
    chk("t5_rst_last", 32'(ol[0]), 32'd0);
    chk("t5_rst_ready", 32'(ir[0]), 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    chk("t5_ready_after", 32'(ir[0]), 32'd1);
    do_flush();
    chk("t5_discarded", 32'(ov[0]), 32'd0);
    step();

    // Random stream against the bit-FIFO model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) step();
    do_flush();
    step();
    step();
    chk("rand_drained_sat", 32'(tl[0] - hd[0]), 32'd0);
    chk("rand_drained_trunc", 32'(tl[1] - hd[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
